// File: rtl/product_bcd_converter_if.sv
// Handshake bundle between the multiplier producer, the BCD converter and the display consumer.
// The converter takes the slave modport; the environment around it takes master.
interface product_bcd_converter_if #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
);
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      product;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   bcd;
    logic                  busy;

    modport master (
        output in_valid, product, out_ready,
        input  in_ready, out_valid, bcd, busy
    );

    modport slave (
        input  in_valid, product, out_ready,
        output in_ready, out_valid, bcd, busy
    );
endinterface

// File: rtl/product_bcd_converter.sv
// Sequential double-dabble converter: one product in flight, one binary bit
// shifted into the BCD digit register per clock, result held in bcd until the next completion.
module product_bcd_converter #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input logic clk,
    input logic areset,
    product_bcd_converter_if.slave bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int BCD_W = 4 * DIGITS;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   bin_sr;
    logic [BCD_W-1:0]   digits;
    logic [BCD_W-1:0]   adjusted;
    logic [BCD_W-1:0]   shifted;
    logic [CNT_W-1:0]   cnt;
    logic [BCD_W-1:0]   bcd_reg;
    logic               last_step;

    assign last_step = (cnt == CNT_W'(WIDTH - 1));

    // Add-3 stays inside each 4-bit digit; no carry crosses digit boundaries.
    always_comb begin
        adjusted = digits;
        for (int d = 0; d < DIGITS; d++) begin
            if (digits[4*d +: 4] >= 4'd5)
                adjusted[4*d +: 4] = digits[4*d +: 4] + 4'd3;
        end
        shifted = {adjusted[BCD_W-2:0], bin_sr[WIDTH-1]};
    end

    always_ff @(posedge clk) begin
        if (areset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.in_valid) state_next = SHIFT;
            SHIFT:   if (last_step)    state_next = DONE;
            DONE:    if (bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
        bus.busy      = (state != IDLE);
        bus.bcd       = bcd_reg;
    end

    // bcd_reg only moves on the final shift, so the previous result survives IDLE and SHIFT.
    always_ff @(posedge clk) begin
        if (areset) begin
            bin_sr  <= '0;
            digits  <= '0;
            cnt     <= '0;
            bcd_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        bin_sr <= bus.product;
                        digits <= '0;
                        cnt    <= '0;
                    end
                end
                SHIFT: begin
                    bin_sr <= {bin_sr[WIDTH-2:0], 1'b0};
                    digits <= shifted;
                    if (last_step)
                        bcd_reg <= shifted;
                    else
                        cnt <= cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_product_bcd_converter.sv
// Directed and randomised checks of the BCD converter: reset, known vectors,
// output stall, input ignore during SHIFT, mid-conversion reset and a sweep against a decimal model.
module tb_product_bcd_converter;
    logic clk;
    logic areset;
    int   checks;
    int   failures;

    product_bcd_converter_if #(.WIDTH(16), .DIGITS(5)) bus ();

    product_bcd_converter #(.WIDTH(16), .DIGITS(5)) dut (
        .clk    (clk),
        .areset (areset),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [19:0] to_bcd(input int unsigned v);
        logic [19:0] r;
        int unsigned x;
        x = v;
        r = '0;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a product for one acceptance edge, then drops in_valid.
    task automatic start(input logic [15:0] p);
        bus.in_valid = 1'b1;
        bus.product  = p;
        tick();
        bus.in_valid = 1'b0;
    endtask

    // Counts edges after acceptance until out_valid rises, bounded.
    task automatic wait_done(output int lat, output bit timed_out);
        lat = 0;
        timed_out = 1'b0;
        while (bus.out_valid !== 1'b1) begin
            if (lat >= 40) begin
                timed_out = 1'b1;
                return;
            end
            tick();
            lat++;
        end
    endtask

    task automatic pop();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        areset = 1'b1;
        tick();
        tick();
        areset = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_in_ready got=%b exp=1", bus.in_ready);
        end
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_out_valid got=%b exp=0", bus.out_valid);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_busy got=%b exp=0", bus.busy);
        end
        checks++;
        if (bus.bcd !== 20'h00000) begin
            failures++;
            $display("[TB] FAIL reset_bcd got=%h exp=00000", bus.bcd);
        end
    endtask

    task automatic test_vectors();
        logic [15:0] prods [4] = '{16'd0, 16'd12345, 16'd65535, 16'd225};
        logic [19:0] exps  [4] = '{20'h00000, 20'h12345, 20'h65535, 20'h00225};
        int lat;
        bit to;
        for (int i = 0; i < 4; i++) begin
            start(prods[i]);
            checks++;
            if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
                failures++;
                $display("[TB] FAIL vec_busy[%0d] got busy=%b in_ready=%b exp busy=1 in_ready=0",
                         i, bus.busy, bus.in_ready);
            end
            wait_done(lat, to);
            checks++;
            if (to || lat != 16) begin
                failures++;
                $display("[TB] FAIL vec_latency[%0d] got=%0d timeout=%0b exp=16", i, lat, to);
            end
            checks++;
            if (bus.bcd !== exps[i]) begin
                failures++;
                $display("[TB] FAIL vec_bcd[%0d] got=%h exp=%h", i, bus.bcd, exps[i]);
            end
            pop();
            checks++;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
                failures++;
                $display("[TB] FAIL vec_release[%0d] got out_valid=%b in_ready=%b exp 0/1",
                         i, bus.out_valid, bus.in_ready);
            end
        end
    endtask

    task automatic test_hold();
        int lat;
        bit to;
        bit bad;
        start(16'd4096);
        wait_done(lat, to);
        bad = to;
        for (int c = 0; c < 10; c++) begin
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.bcd !== 20'h04096)
                bad = 1'b1;
            tick();
        end
        checks++;
        if (bad) begin
            failures++;
            $display("[TB] FAIL hold_stall got out_valid=%b in_ready=%b bcd=%h exp 1/0/04096",
                     bus.out_valid, bus.in_ready, bus.bcd);
        end
        pop();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.bcd !== 20'h04096) begin
            failures++;
            $display("[TB] FAIL hold_release got out_valid=%b in_ready=%b bcd=%h exp 0/1/04096",
                     bus.out_valid, bus.in_ready, bus.bcd);
        end
    endtask

    task automatic test_early_ready();
        int lat;
        bit to;
        bus.out_ready = 1'b1;
        start(16'd808);
        wait_done(lat, to);
        checks++;
        if (to || lat != 16 || bus.bcd !== 20'h00808) begin
            failures++;
            $display("[TB] FAIL early_ready_result got lat=%0d bcd=%h exp lat=16 bcd=00808", lat, bus.bcd);
        end
        tick();
        bus.out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL early_ready_pulse got out_valid=%b in_ready=%b exp 0/1",
                     bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_ignore_inputs();
        int lat;
        bit to;
        bus.in_valid = 1'b1;
        bus.product  = 16'd1234;
        tick();
        for (int c = 0; c < 8; c++) begin
            bus.product = 16'(9000 + c * 111);
            tick();
        end
        checks++;
        if (bus.bcd !== 20'h00808) begin
            failures++;
            $display("[TB] FAIL bcd_kept_in_shift got=%h exp=00808", bus.bcd);
        end
        wait_done(lat, to);
        bus.in_valid = 1'b0;
        checks++;
        if (to || lat != 8 || bus.bcd !== 20'h01234) begin
            failures++;
            $display("[TB] FAIL ignore_inputs got lat=%0d bcd=%h exp lat=8 bcd=01234", lat, bus.bcd);
        end
        pop();
    endtask

    task automatic test_reset_mid_shift();
        int lat;
        bit to;
        start(16'd4321);
        for (int c = 0; c < 6; c++) tick();
        areset = 1'b1;
        tick();
        areset = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.bcd !== 20'h0) begin
            failures++;
            $display("[TB] FAIL mid_reset got in_ready=%b out_valid=%b busy=%b bcd=%h exp 1/0/0/00000",
                     bus.in_ready, bus.out_valid, bus.busy, bus.bcd);
        end
        start(16'd999);
        wait_done(lat, to);
        checks++;
        if (to || lat != 16 || bus.bcd !== 20'h00999) begin
            failures++;
            $display("[TB] FAIL after_reset got lat=%0d bcd=%h exp lat=16 bcd=00999", lat, bus.bcd);
        end
        pop();
    endtask

    task automatic test_sweep();
        int lat;
        bit to;
        int guard;
        logic [15:0] p;
        for (int n = 0; n < 120; n++) begin
            p = 16'($urandom_range(0, 65535));
            checks++;
            if (bus.in_ready !== 1'b1) begin
                failures++;
                $display("[TB] FAIL sweep_ready[%0d] got=%b exp=1", n, bus.in_ready);
            end
            bus.out_ready = 1'($urandom_range(0, 1));
            start(p);
            wait_done(lat, to);
            checks++;
            if (to || lat != 16 || bus.bcd !== to_bcd(int'(p))) begin
                failures++;
                $display("[TB] FAIL sweep[%0d] p=%0d got lat=%0d bcd=%h exp lat=16 bcd=%h",
                         n, p, lat, bus.bcd, to_bcd(int'(p)));
            end
            guard = 0;
            while (bus.out_valid === 1'b1 && guard < 30) begin
                bus.out_ready = 1'($urandom_range(0, 1));
                tick();
                guard++;
            end
            bus.out_ready = 1'b0;
        end
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        areset        = 1'b0;
        bus.in_valid  = 1'b0;
        bus.product   = '0;
        bus.out_ready = 1'b0;
        tick();
        test_reset();
        test_vectors();
        test_hold();
        test_early_ready();
        test_ignore_inputs();
        test_reset_mid_shift();
        test_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
